// File: rtl/shift_seq_ctrl.sv
// Purpose : load/shift sequencer for a WIDTH-bit shift register. It loads once, shifts len times, then pulses done.
// Latency : start seen at edge k -> sr_ld in cycle k+1, sr_shen in k+2..k+len_q+1, done in k+len_q+2.
// Backpr. : none. A start is taken only in IDLE, and abort cancels the transfer within the same cycle.
//
// Ports:
//   clk, rst          single clock; synchronous active-high reset
//   start, len        transfer request and shift count (len is sampled together with start)
//   abort             cancels a transfer in progress and clears the datapath
//   sr_sclr/ld/shen   shift-register clear, parallel-load and shift-enable controls
//   busy, done        transfer in progress; one-cycle completion pulse
//   shift_cnt         shifts performed so far in the current or last transfer
module shift_seq_ctrl #(
    parameter int WIDTH = 10,
    parameter int CNT_W = 4     // 2**CNT_W must exceed WIDTH so cnt can reach len_q
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic [CNT_W-1:0] len,
    output logic             sr_sclr,
    output logic             sr_ld,
    output logic             sr_shen,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] shift_cnt
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        SHIFT = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] WIDTH_C = CNT_W'(WIDTH);
    localparam logic [CNT_W-1:0] ONE_C   = CNT_W'(1);

    state_t           state, state_nxt;
    logic [CNT_W-1:0] len_q, len_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic [CNT_W-1:0] len_clamp;

    // A transfer never shifts more bits than the register holds.
    assign len_clamp = (len > WIDTH_C) ? WIDTH_C : len;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            len_q <= '0;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            len_q <= len_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        len_nxt   = len_q;
        cnt_nxt   = cnt;

        case (state)
            IDLE: begin
                // Abort has priority over start. A zero-length request completes
                // without any ld or shen pulse.
                if (start && !abort) begin
                    len_nxt   = len_clamp;
                    cnt_nxt   = '0;
                    state_nxt = (len == '0) ? DONE : LOAD;
                end
            end
            LOAD: begin
                cnt_nxt   = '0;
                state_nxt = abort ? IDLE : SHIFT;
            end
            SHIFT: begin
                if (abort) begin
                    cnt_nxt   = '0;
                    state_nxt = IDLE;
                end else begin
                    cnt_nxt = cnt + ONE_C;
                    // cnt still holds the pre-increment value in this cycle, so
                    // matching len_q-1 here means this is the final shift.
                    if (cnt == (len_q - ONE_C)) begin
                        state_nxt = DONE;
                    end
                end
            end
            DONE: begin
                // A start seen here is ignored on purpose. The done pulse still
                // completes even if abort is high. cnt keeps its final value.
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // The outputs are decoded from state and abort only. They are forced to
    // their reset values while rst is high, so a reset in the middle of a
    // transfer cannot leak a load or shift pulse.
    always_comb begin
        sr_sclr   = rst | abort;
        sr_ld     = 1'b0;
        sr_shen   = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        shift_cnt = '0;
        if (!rst) begin
            sr_ld     = (state == LOAD)  && !abort;
            sr_shen   = (state == SHIFT) && !abort;
            busy      = (state != IDLE);
            done      = (state == DONE);
            shift_cnt = cnt;
        end
    end

endmodule

// File: doc/shift_seq_ctrl.md
Name: shift_seq_ctrl

Overview:
- Sequencer for the 10-bit parallel-load / serial-shift register. Drives its clear, load and shift-enable controls.
- Run a transfer: load once, shift exactly N times, report completion.
- Sits between the top-level control (start/abort handshake) and the shift-register datapath. Used for serialisers and for bit-serial arithmetic steps.

Parameters:
WIDTH, 10, width of the controlled shift register; maximum shifts per transfer
CNT_W, 4, width of the length input and bit counter; must satisfy 2^CNT_W > WIDTH

Ports:
clk  input  1  rising-edge clock, single clock domain
rst  input  1  synchronous active-high reset
start  input  1  request a transfer; sampled only in IDLE
abort  input  1  cancel the transfer in progress and clear the datapath
len  input  CNT_W  number of shift cycles requested; sampled with start
sr_sclr  output  1  clear control to the shift register
sr_ld  output  1  parallel-load control to the shift register
sr_shen  output  1  shift-enable control to the shift register
busy  output  1  high whenever state is not IDLE
done  output  1  one-cycle completion pulse
shift_cnt  output  CNT_W  shifts performed so far in the current transfer

Behaviour:
- Interface (decided): one clock, clk. Reset rst is synchronous and active-high; no asynchronous paths.
- States:
  - IDLE, LOAD, SHIFT, DONE, state register plus len_q (CNT_W) and cnt (CNT_W).
  - Reset puts state=IDLE, len_q=0, cnt=0.
- Outputs while rst is high: sr_sclr=1, sr_ld=0, sr_shen=0, busy=0, done=0, shift_cnt=0.
- Output decode, from state and abort only:
  - sr_ld = (LOAD & ~abort).
  - sr_shen = (SHIFT & ~abort).
  - sr_sclr = rst | abort.
  - done = DONE.
  - busy = state != IDLE.
  - shift_cnt = cnt.
- Length rule: len_q = min(len, WIDTH), latched on the accepted start.
- IDLE:
  - start=1, len!=0 -> LOAD; cnt=0.
  - start=1, len=0 -> DONE directly. No ld or shen pulse is issued.
  - start=0 -> stay in IDLE.
- LOAD: exactly one cycle with sr_ld=1 -> SHIFT; cnt=0.
- SHIFT:
  - sr_shen=1 every cycle; cnt increments by 1 per cycle.
  - If cnt == len_q-1 in this cycle -> DONE; cnt reaches len_q.
  - Exactly len_q shen pulses per transfer.
- DONE:
  - done=1 for one cycle -> IDLE.
  - cnt holds its final value until the next accepted start.
  - A start seen in DONE is ignored. It must be held into IDLE to be accepted.
- Latency: start sampled at edge k -> sr_ld high in cycle k+1 -> sr_shen high in cycles k+2..k+len_q+1 -> done in cycle k+len_q+2.
- Abort:
  - In LOAD or SHIFT: sr_sclr=1 that cycle, ld/shen suppressed, next state IDLE, cnt=0, no done pulse.
  - In IDLE or DONE: sr_sclr=1 that cycle. If abort=1 in IDLE, start is ignored that cycle. In DONE the done pulse still completes.
- Simultaneous events:
  - rst dominates abort, abort dominates start.
  - Reset mid-transfer returns to IDLE next edge with no done pulse.
- Counter never wraps: len_q ≤ WIDTH < 2^CNT_W.

Test Plan:
- Basic transfer: rst 2 cycles, then start=1, len=4 for one cycle -> sr_ld high 1 cycle, sr_shen high exactly 4 cycles, done pulse 6 cycles after the start edge, busy high 6 cycles, shift_cnt ends at 4.
- Zero length: start, len=0 -> no sr_ld, no sr_shen, done in the next cycle, busy high 1 cycle.
- Clamp: start, len=15 with WIDTH=10 -> exactly 10 sr_shen cycles, shift_cnt=10 at done.
- Abort mid-shift: start, len=8, assert abort in the 3rd shift cycle -> sr_sclr=1 and sr_shen=0 that cycle, busy low next cycle, no done pulse, shift_cnt=0.
- Start held high across DONE: start stuck at 1, len=2 -> back-to-back transfers, each with 1 ld and 2 shen. Exactly one IDLE cycle between the done pulse and the next sr_ld.
- Reset mid-load: rst asserted during the LOAD cycle -> sr_ld=0 and sr_sclr=1 that cycle, IDLE next cycle, all outputs at reset values.
